// File: rtl/sound_pkg.sv
// Shared types and constants for the sound arbiter: FSM states, source codes,
// mode type and per-source tone frequencies.
package sound_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MOVE = 2'd1,
      SRC_GOOD = 2'd2,
      SRC_BAD  = 2'd3
   } src_t;

   typedef enum logic {
      MODE_OFF = 1'b0,
      MODE_ON  = 1'b1
   } mode_t;

   localparam logic [8:0] FREQ_BAD  = 9'd311;
   localparam logic [8:0] FREQ_GOOD = 9'd440;
   localparam logic [8:0] FREQ_MOVE = 9'd262;

   function automatic logic [8:0] freq_of(input logic [1:0] src);
      case (src)
         SRC_BAD:  freq_of = FREQ_BAD;
         SRC_GOOD: freq_of = FREQ_GOOD;
         SRC_MOVE: freq_of = FREQ_MOVE;
         default:  freq_of = 9'd0;
      endcase
   endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// Request/tone bus between the sound requesters and the arbiter.
interface sound_arbiter_if;
   logic       enable;
   logic       req_bad;
   logic       req_good;
   logic       req_move;
   logic [8:0] freq;
   logic       playSound;
   logic [1:0] active_src;
   logic       busy;
   logic [7:0] drop_cnt;

   modport slave (
      input  enable, req_bad, req_good, req_move,
      output freq, playSound, active_src, busy, drop_cnt
   );

   modport master (
      output enable, req_bad, req_good, req_move,
      input  freq, playSound, active_src, busy, drop_cnt
   );
endinterface

// File: rtl/sound_prio_enc.sv
// Fixed-priority encoder over {bad, good, move}: returns the winning source
// code and its one-hot grant.
module sound_prio_enc
   import sound_pkg::*;
(
   input  logic [2:0] cand,
   output logic [1:0] src,
   output logic [2:0] grant
);

   always_comb begin
      src   = SRC_NONE;
      grant = 3'b000;
      if (cand[2]) begin
         src   = SRC_BAD;
         grant = 3'b100;
      end else if (cand[1]) begin
         src   = SRC_GOOD;
         grant = 3'b010;
      end else if (cand[0]) begin
         src   = SRC_MOVE;
         grant = 3'b001;
      end
   end

endmodule

// File: rtl/sound_arbiter.sv
// Shares the tone datapath between bad/good/move requesters with fixed
// priority, preemption, one pending slot per source and a gap between notes.
//
//   state  | meaning
//   S_IDLE | silent, nothing pending
//   S_PLAY | note sounding, counter runs down the note duration
//   S_GAP  | silent spacer, counter runs down the gap length
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int DUR_BAD  = 40,
   parameter int DUR_GOOD = 20,
   parameter int DUR_MOVE = 5,
   parameter int GAP      = 2,
   parameter int CW       = 6
) (
   input logic             clk,
   input logic             nRst,
   sound_arbiter_if.slave  bus
);

   state_t        state;
   logic [2:0]    pending;
   logic [CW-1:0] cnt;
   logic [8:0]    freq_q;
   logic          play_q;
   logic [1:0]    active_q;
   logic          busy_q;
   logic [7:0]    drop_q;

   logic [2:0] req, cand, drops;
   logic [1:0] cand_src, req_src, launch_src, n_drop;
   logic [2:0] cand_grant, req_grant, launch_pend;
   logic [8:0] drop_sum;
   logic [7:0] drop_next;
   logic       launch;

   function automatic logic [CW-1:0] dur_of(input logic [1:0] src);
      case (src)
         SRC_BAD:  dur_of = CW'(DUR_BAD - 1);
         SRC_GOOD: dur_of = CW'(DUR_GOOD - 1);
         default:  dur_of = CW'(DUR_MOVE - 1);
      endcase
   endfunction

   assign req  = {bus.req_bad, bus.req_good, bus.req_move};
   assign cand = pending | req;

   sound_prio_enc u_cand_enc (.cand(cand), .src(cand_src), .grant(cand_grant));
   sound_prio_enc u_req_enc  (.cand(req),  .src(req_src),  .grant(req_grant));

   // A repeat request for a source that already holds a pending slot is lost.
   assign drops     = req & pending;
   assign n_drop    = 2'(drops[0]) + 2'(drops[1]) + 2'(drops[2]);
   assign drop_sum  = {1'b0, drop_q} + {7'd0, n_drop};
   assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

   always_comb begin
      launch      = 1'b0;
      launch_src  = cand_src;
      launch_pend = cand & ~cand_grant;
      case (state)
         S_IDLE: launch = |cand;
         S_PLAY: begin
            // Only a fresh request can outrank the playing note; the loser is discarded.
            if (req_src > active_q) begin
               launch      = 1'b1;
               launch_src  = req_src;
               launch_pend = cand & ~req_grant;
            end
         end
         S_GAP:   launch = (cnt == '0) && (|cand);
         default: launch = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= S_IDLE;
         pending  <= 3'b000;
         cnt      <= '0;
         freq_q   <= 9'd0;
         play_q   <= 1'b0;
         active_q <= SRC_NONE;
         busy_q   <= 1'b0;
         drop_q   <= 8'd0;
      end else if (bus.enable != MODE_ON) begin
         state    <= S_IDLE;
         pending  <= 3'b000;
         cnt      <= '0;
         freq_q   <= 9'd0;
         play_q   <= 1'b0;
         active_q <= SRC_NONE;
         busy_q   <= 1'b0;
      end else begin
         drop_q <= drop_next;
         if (launch) begin
            state    <= S_PLAY;
            cnt      <= dur_of(launch_src);
            freq_q   <= freq_of(launch_src);
            play_q   <= 1'b1;
            active_q <= launch_src;
            pending  <= launch_pend;
            busy_q   <= 1'b1;
         end else begin
            case (state)
               S_PLAY: begin
                  pending <= cand;
                  busy_q  <= 1'b1;
                  if (cnt == '0) begin
                     state    <= S_GAP;
                     cnt      <= CW'(GAP - 1);
                     freq_q   <= 9'd0;
                     play_q   <= 1'b0;
                     active_q <= SRC_NONE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_GAP: begin
                  pending <= cand;
                  if (cnt == '0) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     cnt    <= cnt - 1'b1;
                     busy_q <= 1'b1;
                  end
               end
               default: begin
                  state   <= S_IDLE;
                  pending <= cand;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.freq       = freq_q;
   assign bus.playSound  = play_q;
   assign bus.active_src = active_q;
   assign bus.busy       = busy_q;
   assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed, table-driven bench for sound_arbiter with hand sequences for
// drop-counter saturation and asynchronous reset mid-note.
module tb_sound_arbiter;

   logic clk;
   logic nRst;
   int   checks = 0;
   int   errors = 0;

   sound_arbiter_if bus ();

   sound_arbiter dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic       en, b, g, m;
      logic       play;
      logic [8:0] freq;
      logic [1:0] src;
      logic       busy;
      logic [7:0] drop;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(int n, logic en, logic b, logic g, logic m,
                                logic play, logic [8:0] freq, logic [1:0] src,
                                logic busy, logic [7:0] drop);
      vec_t v;
      v.n = n; v.en = en; v.b = b; v.g = g; v.m = m;
      v.play = play; v.freq = freq; v.src = src; v.busy = busy; v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic play, input logic [8:0] freq,
                           input logic [1:0] src, input logic busy, input logic [7:0] drop);
      chk({tag, ".playSound"},  16'(bus.playSound),  16'(play));
      chk({tag, ".freq"},       16'(bus.freq),       16'(freq));
      chk({tag, ".active_src"}, 16'(bus.active_src), 16'(src));
      chk({tag, ".busy"},       16'(bus.busy),       16'(busy));
      chk({tag, ".drop_cnt"},   16'(bus.drop_cnt),   16'(drop));
   endtask

   task automatic run_row(input string tag, input vec_t v);
      for (int k = 0; k < v.n; k++) begin
         bus.enable   = v.en;
         bus.req_bad  = (k == 0) ? v.b : 1'b0;
         bus.req_good = (k == 0) ? v.g : 1'b0;
         bus.req_move = (k == 0) ? v.m : 1'b0;
         @(posedge clk);
         #1;
         chk_outs($sformatf("%s.c%0d", tag, k), v.play, v.freq, v.src, v.busy, v.drop);
      end
      bus.req_bad  = 1'b0;
      bus.req_good = 1'b0;
      bus.req_move = 1'b0;
   endtask

   initial begin
      // single good note
      vecs.push_back(row( 1, 1, 0, 1, 0, 1, 9'd440, 2'd2, 1, 8'd0));
      vecs.push_back(row(19, 1, 0, 0, 0, 1, 9'd440, 2'd2, 1, 8'd0));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd0));
      // bad and move together: bad first, move after the gap
      vecs.push_back(row( 1, 1, 1, 0, 1, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row(39, 1, 0, 0, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd0));
      vecs.push_back(row( 5, 1, 0, 0, 0, 1, 9'd262, 2'd1, 1, 8'd0));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd0));
      // move preempted by bad, move not replayed
      vecs.push_back(row( 1, 1, 0, 0, 1, 1, 9'd262, 2'd1, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 0, 0, 1, 9'd262, 2'd1, 1, 8'd0));
      vecs.push_back(row( 1, 1, 1, 0, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row(39, 1, 0, 0, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd0));
      vecs.push_back(row( 3, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd0));
      // good pulsed three times during bad: one pending, two dropped
      vecs.push_back(row( 1, 1, 1, 0, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 1, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 0, 0, 1, 9'd311, 2'd3, 1, 8'd0));
      vecs.push_back(row( 1, 1, 0, 1, 0, 1, 9'd311, 2'd3, 1, 8'd1));
      vecs.push_back(row( 1, 1, 0, 1, 0, 1, 9'd311, 2'd3, 1, 8'd2));
      vecs.push_back(row(35, 1, 0, 0, 0, 1, 9'd311, 2'd3, 1, 8'd2));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd2));
      vecs.push_back(row(20, 1, 0, 0, 0, 1, 9'd440, 2'd2, 1, 8'd2));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd2));
      vecs.push_back(row( 1, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd2));
      // re-request of the playing source queues, not dropped
      vecs.push_back(row( 1, 1, 0, 0, 1, 1, 9'd262, 2'd1, 1, 8'd2));
      vecs.push_back(row( 1, 1, 0, 0, 1, 1, 9'd262, 2'd1, 1, 8'd2));
      vecs.push_back(row( 3, 1, 0, 0, 0, 1, 9'd262, 2'd1, 1, 8'd2));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd2));
      vecs.push_back(row( 5, 1, 0, 0, 0, 1, 9'd262, 2'd1, 1, 8'd2));
      vecs.push_back(row( 2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd2));
      vecs.push_back(row( 1, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd2));
      // enable dropped mid-note with good pending, then re-raised idle
      vecs.push_back(row( 1, 1, 1, 0, 0, 1, 9'd311, 2'd3, 1, 8'd2));
      vecs.push_back(row( 1, 1, 0, 1, 0, 1, 9'd311, 2'd3, 1, 8'd2));
      vecs.push_back(row( 3, 1, 0, 0, 0, 1, 9'd311, 2'd3, 1, 8'd2));
      vecs.push_back(row( 1, 0, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd2));
      vecs.push_back(row( 1, 0, 0, 1, 0, 0, 9'd0,   2'd0, 0, 8'd2));
      vecs.push_back(row( 3, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd2));

      nRst         = 1'b0;
      bus.enable   = 1'b1;
      bus.req_bad  = 1'b0;
      bus.req_good = 1'b0;
      bus.req_move = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 9'd0, 2'd0, 1'b0, 8'd0);
      @(negedge clk);
      nRst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++)
         run_row($sformatf("row%0d", i), vecs[i]);

      // held good request drops almost every cycle; counter must stick at 255
      bus.enable   = 1'b1;
      bus.req_good = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("saturate.drop_cnt", 16'(bus.drop_cnt), 16'd255);
      bus.req_good = 1'b0;
      bus.enable   = 1'b0;
      @(posedge clk);
      #1;
      bus.enable = 1'b1;

      // async reset while a bad note sounds
      run_row("pre_rst", row(3, 1, 1, 0, 0, 1, 9'd311, 2'd3, 1, 8'd255));
      @(posedge clk);
      #3;
      nRst = 1'b0;
      #1;
      chk_outs("async_rst", 1'b0, 9'd0, 2'd0, 1'b0, 8'd0);
      @(negedge clk);
      nRst = 1'b1;
      @(posedge clk);
      #1;
      run_row("post_rst_a", row(1, 1, 0, 0, 1, 1, 9'd262, 2'd1, 1, 8'd0));
      run_row("post_rst_b", row(4, 1, 0, 0, 0, 1, 9'd262, 2'd1, 1, 8'd0));
      run_row("post_rst_c", row(2, 1, 0, 0, 0, 0, 9'd0,   2'd0, 1, 8'd0));
      run_row("post_rst_d", row(1, 1, 0, 0, 0, 0, 9'd0,   2'd0, 0, 8'd0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
